mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter in front of the single shared memory port used by the multicycle core.
- Master 0 is the core's memory bus, through a req/ack shim. Master 1 is a secondary requester, such as a boot loader or DMA.
- Grants one transaction at a time using round-robin on contention. Latches the winner's command, drives the memory port for a fixed latency, then returns read data and a one-cycle ack to the owner only.

Parameters:
- ADDR_WIDTH, 32, address width for masters and the memory port.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 1, number of cycles the memory strobe and address are held before read data is valid. Legal range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- m0_req  input  1  master 0 request; held until ack
- m0_we  input  1  master 0 write enable (1 = write, 0 = read)
- m0_addr  input  ADDR_WIDTH  master 0 address
- m0_wdata  input  DATA_WIDTH  master 0 write data
- m0_rdata  output  DATA_WIDTH  master 0 read data, registered
- m0_ack  output  1  master 0 completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1
- grant  output  2  one-hot current owner; bit0 = m0, bit1 = m1
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_address  output  ADDR_WIDTH  memory address
- mem_write_data  output  DATA_WIDTH  memory write data
- mem_read_data  input  DATA_WIDTH  memory read data

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - state IDLE; grant 0; mem_read/mem_write 0.
  - mem_address/mem_write_data 0; m0/m1_rdata 0; acks 0; latency counter 0.
  - last_grant = 1, so m0 wins the first contention.
- State machine:
  - IDLE: strobes 0, grant 0.
    - If exactly one req is high, that master wins.
    - If both are high, the master not equal to last_grant wins.
    - At the edge: latch owner, we, addr, wdata; load counter with MEM_LATENCY-1; go to ACCESS.
  - ACCESS:
    - grant = owner; mem_address/mem_write_data = latched values.
    - mem_read = !we_latched; mem_write = we_latched.
    - If counter == 0: on a read, capture mem_read_data into the owner's rdata register; update last_grant = owner; go to RESPOND.
    - Otherwise decrement the counter and stay.
  - RESPOND: owner's ack = 1 for exactly one cycle; strobes 0; grant still = owner; always go to IDLE.
- Timing (req high in IDLE cycle 0):
  - Strobe is high in cycles 1..MEM_LATENCY.
  - ack is high in cycle MEM_LATENCY+1.
  - rdata is valid from the ack cycle and held until that master's next read completes.
  - Occupancy is MEM_LATENCY+2 cycles per transaction.
- Master rules:
  - A master must drop req in its ack cycle. A req still high in IDLE is a new transaction.
  - Master inputs are sampled only on the IDLE grant edge. Changes during ACCESS/RESPOND are ignored.
  - Dropping req during ACCESS does not abort; the transaction completes and ack still pulses.
- Data rules:
  - A write never changes rdata.
  - The non-owner's ack and rdata never change.
  - mem_read and mem_write are never both 1.
  - grant is never 2'b11.
- Reset mid-transaction: abort with no ack. Strobes, grant and acks are 0 in the cycle after the reset edge. rdata returns to 0.

Test Plan:
1. Reset: hold reset 2 cycles with both reqs high -> all outputs 0; after release, m0 is granted first.
2. m0 read, MEM_LATENCY=2, addr 0x100, memory returns 0xDEADBEEF -> mem_read=1 with mem_address=0x100 in cycles 1-2; m0_ack=1 in cycle 3; m0_rdata=0xDEADBEEF; m1_ack stays 0.
3. Contention: m0 write 0x10/0x11111111 and m1 read 0x20 asserted together -> m0 write first (mem_write=1, mem_write_data=0x11111111), then m1 read. Re-assert both after m1's ack -> m0 served; re-assert both after that -> m1 served (strict alternation).
4. m1 holds req continuously across ack, m0 idle -> back-to-back m1 transactions every MEM_LATENCY+2 cycles, one ack pulse each.
5. m0 changes addr from 0x100 to 0x200 and drops req during ACCESS -> mem_address stays 0x100 and m0_ack still pulses once.
6. Reset asserted in the first ACCESS cycle -> next cycle strobes/grant/acks are 0, no ack is ever produced, and a subsequent m1 req is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter for the shared memory port
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ack,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ack,
   output logic [1:0]            grant,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

   state_t                r_state;
   state_t                w_next;
   logic                  r_owner;
   logic                  r_last_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_cnt;
   logic [DATA_WIDTH-1:0] r_m0_rdata;
   logic [DATA_WIDTH-1:0] r_m1_rdata;
   logic                  w_any;
   logic                  w_win;
   logic [1:0]            w_owner_onehot;

   // On contention the master that did not win last time goes next.
   assign w_any          = m0_req | m1_req;
   assign w_win          = (m0_req & m1_req) ? ~r_last_grant : m1_req;
   assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;

   assign mem_address    = r_addr;
   assign mem_write_data = r_wdata;
   assign m0_rdata       = r_m0_rdata;
   assign m1_rdata       = r_m1_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      grant     = 2'b00;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      m0_ack    = 1'b0;
      m1_ack    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) w_next = ACCESS;
         end
         ACCESS: begin
            grant     = w_owner_onehot;
            mem_read  = ~r_we;
            mem_write = r_we;
            if (r_cnt == 4'd0) w_next = RESPOND;
         end
         RESPOND: begin
            grant  = w_owner_onehot;
            m0_ack = ~r_owner;
            m1_ack = r_owner;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt        <= 4'd0;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner <= w_win;
                  r_we    <= w_win ? m1_we    : m0_we;
                  r_addr  <= w_win ? m1_addr  : m0_addr;
                  r_wdata <= w_win ? m1_wdata : m0_wdata;
                  r_cnt   <= LAT_LOAD;
               end
            end
            ACCESS: begin
               if (r_cnt == 4'd0) begin
                  if (!r_we) begin
                     if (r_owner) r_m1_rdata <= mem_read_data;
                     else         r_m0_rdata <= mem_read_data;
                  end
                  r_last_grant <= r_owner;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;

   localparam int L = 2;

   typedef struct {
      int          m;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m1_ack;
   logic [1:0]  grant;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_write_data;
   logic [31:0] mem_read_data = 32'h0;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        rst_q = 1'b1;
   exp_t        sb[$];
   logic [31:0] env_mem   [0:1023];
   logic [31:0] model_mem [0:1023];
   int          model_last = 1;

   mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .grant(grant), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   function automatic int widx(input logic [31:0] a);
      return int'(a[11:2]);
   endfunction

   // Memory environment: writes land during the strobe, read data follows the address.
   always @(negedge clk) begin
      if (mem_write) env_mem[widx(mem_address)] <= mem_write_data;
      mem_read_data <= env_mem[widx(mem_address)];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic push(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.m = m; e.we = we; e.addr = a; e.wdata = d;
      e.rdata = we ? 32'h0 : model_mem[widx(a)];
      if (we) model_mem[widx(a)] = d;
      sb.push_back(e);
   endtask

   // Model of arbitration: a lone requester is served; on contention the one not served last goes first, then the other.
   task automatic start_round(input bit u0, input bit u1,
                              input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                              input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_req = u0;
      m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_req = u1;
      if (u0 && u1) begin
         if (model_last == 1) begin
            push(0, w0, a0, d0); push(1, w1, a1, d1); model_last = 1;
         end else begin
            push(1, w1, a1, d1); push(0, w0, a0, d0); model_last = 0;
         end
      end else if (u0) begin
         push(0, w0, a0, d0); model_last = 0;
      end else if (u1) begin
         push(1, w1, a1, d1); model_last = 1;
      end
   endtask

   task automatic finish_round(input bit u0, input bit u1, input bit scramble);
      bit d0 = !u0;
      bit d1 = !u1;
      int n = 0;
      while (!(d0 && d1) && n < 200) begin
         @(negedge clk);
         n++;
         if (m0_ack) begin d0 = 1; m0_req = 0; end
         if (m1_ack) begin d1 = 1; m1_req = 0; end
         if (scramble && grant[0] && !m0_ack) begin
            m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) m0_req = 0;
         end
         if (scramble && grant[1] && !m1_ack) begin
            m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) m1_req = 0;
         end
      end
      if (!(d0 && d1)) fail_now("round_timeout");
   endtask

   // Monitor: every ack pops the scoreboard and is compared with the command seen on the memory port.
   logic [31:0] exp_rd0 = 0, exp_rd1 = 0;
   logic [31:0] cur_addr, cur_wd;
   logic        cur_we;
   logic [1:0]  cur_g;
   int          cur_n = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_q) begin
         exp_rd0 = 0; exp_rd1 = 0; cur_n = 0;
         chk("rst_grant", 32'(grant), 32'h0);
         chk("rst_strobes", 32'({mem_read, mem_write}), 32'h0);
         chk("rst_acks", 32'({m0_ack, m1_ack}), 32'h0);
         chk("rst_rdata0", m0_rdata, 32'h0);
         chk("rst_rdata1", m1_rdata, 32'h0);
      end else begin
         chk("strobe_excl", 32'(mem_read & mem_write), 32'h0);
         chk("grant_not_11", 32'(grant == 2'b11), 32'h0);
         if (mem_read || mem_write) begin
            if (cur_n == 0) begin
               cur_addr = mem_address; cur_we = mem_write; cur_wd = mem_write_data; cur_g = grant;
            end else begin
               chk("addr_stable", mem_address, cur_addr);
            end
            cur_n++;
         end
         if (m0_ack && m1_ack) begin
            fail_now("both_acks");
         end else if (m0_ack || m1_ack) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_ack");
            end else begin
               e = sb.pop_front();
               chk("ack_master", 32'(m1_ack), 32'(e.m));
               chk("ack_grant", 32'(grant), (e.m == 1) ? 32'h2 : 32'h1);
               chk("strobe_cycles", 32'(cur_n), 32'(L));
               chk("strobe_grant", 32'(cur_g), (e.m == 1) ? 32'h2 : 32'h1);
               chk("cmd_we", 32'(cur_we), 32'(e.we));
               chk("cmd_addr", cur_addr, e.addr);
               if (e.we) chk("cmd_wdata", cur_wd, e.wdata);
               else if (e.m == 1) exp_rd1 = e.rdata;
               else exp_rd0 = e.rdata;
            end
            cur_n = 0;
         end
         chk("rdata0", m0_rdata, exp_rd0);
         chk("rdata1", m1_rdata, exp_rd1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t[4];
      int n;
      int sel;
      for (int i = 0; i < 1024; i++) begin
         env_mem[i]   = {i[15:0], ~i[15:0]};
         model_mem[i] = {i[15:0], ~i[15:0]};
      end
      env_mem[widx(32'h100)]   = 32'hDEADBEEF;
      model_mem[widx(32'h100)] = 32'hDEADBEEF;
      reset = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

      // Reset held with both requesting, then m0 must win first.
      @(negedge clk);
      start_round(1, 1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h44, 32'h77);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      finish_round(1, 1, 0);

      // m0 read of 0xDEADBEEF.
      start_round(1, 0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
      finish_round(1, 0, 0);
      @(negedge clk);
      chk("t2_rdata", m0_rdata, 32'hDEADBEEF);

      // Contention and alternation.
      start_round(1, 1, 1'b1, 32'h10, 32'h11111111, 1'b0, 32'h20, 32'h0);
      finish_round(1, 1, 0);
      start_round(1, 1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h24, 32'h22222222);
      finish_round(1, 1, 0);
      start_round(1, 1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h10, 32'h0);
      finish_round(1, 1, 0);

      // m1 holds req across acks: back-to-back service.
      start_round(0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h80, 32'h0);
      for (int j = 1; j < 4; j++) push(1, 1'(j & 1), 32'h80 + 32'(j * 4), 32'hB0B0_0000 + 32'(j));
      model_last = 1;
      for (int j = 0; j < 4; j++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!m1_ack && n < 50);
         if (!m1_ack) fail_now("b2b_timeout");
         t[j] = cyc;
         if (j < 3) begin
            m1_we = 1'((j + 1) & 1); m1_addr = 32'h80 + 32'((j + 1) * 4); m1_wdata = 32'hB0B0_0000 + 32'(j + 1);
         end else begin
            m1_req = 0;
         end
      end
      for (int j = 1; j < 4; j++) chk("b2b_gap", 32'(t[j] - t[j-1]), 32'(L + 2));

      // Inputs changed and req dropped during ACCESS are ignored.
      start_round(1, 0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0);
      n = 0;
      do begin @(negedge clk); n++; end while (!grant[0] && n < 20);
      m0_addr = 32'h200; m0_req = 0;
      finish_round(1, 0, 0);
      repeat (4) @(negedge clk);

      // Reset in first ACCESS cycle aborts without ack.
      m0_we = 0; m0_addr = 32'h300; m0_req = 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!grant[0] && n < 20);
      if (!grant[0]) fail_now("t6_no_grant");
      reset = 1'b1; m0_req = 0;
      @(negedge clk);
      reset = 1'b0;
      model_last = 1;
      repeat (3) @(negedge clk);
      start_round(0, 1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h304, 32'h0);
      finish_round(0, 1, 0);

      // Randomized rounds with inputs scrambled while owned.
      for (int r = 0; r < 60; r++) begin
         sel = $urandom_range(1, 3);
         start_round(sel[0], sel[1],
                     1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom,
                     1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom);
         finish_round(sel[0], sel[1], 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
